i2c_glitch_sequencer: RTL

//   Arms on request, watches the decoded byte stream from the I2C bus listener,
//   and matches a 2-byte prefix: address+R/W byte, then register byte.
//   On a match it waits a programmed delay, then drives one glitch pulse of

---
 rtl/i2c_glitch_sequencer.sv | 113 +++++++++++
 1 files changed

// File: rtl/i2c_glitch_sequencer.sv
// Arms on request, matches an address+register prefix in the I2C listener byte
// stream, then fires one delayed glitch pulse of programmed width per arm.
module i2c_glitch_sequencer #(
  parameter int DELAY_W     = 16,
  parameter int PULSE_W     = 8,
  parameter int REQUIRE_ACK = 1
) (
  input  logic               sysclk,
  input  logic               rst,
  input  logic               arm,
  input  logic               abort,
  input  logic               sop,
  input  logic               eot,
  input  logic               byte_ready,
  input  logic [8:0]         byte_in,
  input  logic [7:0]         match_addr,
  input  logic [7:0]         match_reg,
  input  logic [DELAY_W-1:0] delay,
  input  logic [PULSE_W-1:0] pulse_len,
  output logic               glitch_out,
  output logic               armed,
  output logic               busy,
  output logic               done,
  output logic [2:0]         state_dbg
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_SOP   = 3'd1,
    MATCH_ADDR = 3'd2,
    MATCH_REG  = 3'd3,
    DELAY      = 3'd4,
    FIRE       = 3'd5,
    DONE       = 3'd6
  } state_t;

  localparam logic [DELAY_W-1:0] ONE_D = {{(DELAY_W-1){1'b0}}, 1'b1};
  localparam logic [PULSE_W-1:0] ONE_P = {{(PULSE_W-1){1'b0}}, 1'b1};

  state_t             state_reg;
  logic [DELAY_W-1:0] dcnt_reg;
  logic [PULSE_W-1:0] pcnt_reg;
  logic [PULSE_W-1:0] plen_reg;
  logic               ack_ok;
  logic               addr_hit;
  logic               reg_hit;

  assign ack_ok   = (REQUIRE_ACK == 0) || (byte_in[0] == 1'b0);
  assign addr_hit = (byte_in[8:1] == match_addr) && ack_ok;
  assign reg_hit  = (byte_in[8:1] == match_reg) && ack_ok;

  assign armed     = (state_reg == WAIT_SOP) || (state_reg == MATCH_ADDR) || (state_reg == MATCH_REG);
  assign busy      = (state_reg == DELAY) || (state_reg == FIRE);
  assign state_dbg = state_reg;

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      dcnt_reg   <= '0;
      pcnt_reg   <= '0;
      plen_reg   <= '0;
      glitch_out <= 1'b0;
      done       <= 1'b0;
    end else begin
      // Pulse and strobe trail the state by one edge; abort cancels them immediately.
      glitch_out <= (state_reg == FIRE) && !abort;
      done       <= (state_reg == DONE) && !abort;
      if (abort) begin
        state_reg <= IDLE;
        dcnt_reg  <= '0;
        pcnt_reg  <= '0;
      end else begin
        case (state_reg)
          IDLE: if (arm) state_reg <= WAIT_SOP;
          WAIT_SOP: if (sop) state_reg <= MATCH_ADDR;
          MATCH_ADDR: begin
            if (sop)             state_reg <= MATCH_ADDR;
            else if (eot)        state_reg <= WAIT_SOP;
            else if (byte_ready) state_reg <= addr_hit ? MATCH_REG : WAIT_SOP;
          end
          MATCH_REG: begin
            if (sop)        state_reg <= MATCH_ADDR;
            else if (eot)   state_reg <= WAIT_SOP;
            else if (byte_ready) begin
              if (reg_hit) begin
                state_reg <= DELAY;
                dcnt_reg  <= delay;
                plen_reg  <= pulse_len;
              end else begin
                state_reg <= WAIT_SOP;
              end
            end
          end
          DELAY: begin
            if (dcnt_reg == '0) begin
              state_reg <= FIRE;
              pcnt_reg  <= (plen_reg == '0) ? ONE_P : plen_reg;
            end else begin
              dcnt_reg <= dcnt_reg - ONE_D;
            end
          end
          FIRE: begin
            if (pcnt_reg <= ONE_P) state_reg <= DONE;
            if (pcnt_reg != '0)    pcnt_reg  <= pcnt_reg - ONE_P;
          end
          DONE:    state_reg <= IDLE;
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

endmodule
